axis_traffic_checker: RTL and testbench

- Synthesizable AXI-Stream sink/checker that replaces the testbench-only packet monitor behind massive_traffic_injector.
- Parses each beat's header {queue_id, word_cnt} and checks beat sequence, packet length, tkeep and cross-packet round-robin order.
- Drives tready from an LFSR-based random backpressure generator and exposes saturating statistics for on-chip and bench use.

---
 rtl/axis_traffic_checker.sv | 198 +++++++++++++++++++
 tb/tb_axis_traffic_checker.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_traffic_checker.sv
// AXI-Stream sink that checks packet framing, sequence and round-robin order.
// LFSR-driven backpressure and saturating error statistics.
module axis_traffic_checker #(
    parameter int          DATA_WIDTH        = 512,
    parameter int          QUEUE_INDEX_WIDTH = 16,
    parameter int          CNT_WIDTH         = 16,
    parameter int          PKT_LEN_BYTES     = 1536,
    parameter int          STAT_WIDTH        = 64,
    parameter int          ERR_WIDTH         = 32,
    parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_WIDTH-1:0]        s_axis_pkt_tdata,
    input  logic                         s_axis_pkt_tvalid,
    input  logic                         s_axis_pkt_tlast,
    input  logic [DATA_WIDTH/8-1:0]      s_axis_pkt_tkeep,
    output logic                         s_axis_pkt_tready,
    input  logic                         rr_check_en,
    input  logic                         bp_enable,
    input  logic [7:0]                   bp_threshold,
    input  logic                         stat_clear,
    output logic [STAT_WIDTH-1:0]        pkt_count,
    output logic [STAT_WIDTH-1:0]        beat_count,
    output logic [ERR_WIDTH-1:0]         err_seq_count,
    output logic [ERR_WIDTH-1:0]         err_len_count,
    output logic [ERR_WIDTH-1:0]         err_rr_count,
    output logic [QUEUE_INDEX_WIDTH-1:0] last_queue_id,
    output logic                         err_sticky,
    output logic                         err_pulse
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int WORDS = (PKT_LEN_BYTES + BYTES - 1) / BYTES;
    localparam int REM   = PKT_LEN_BYTES % BYTES;
    localparam logic [BYTES-1:0] KEEP_ALL = '1;
    localparam logic [BYTES-1:0] KEEP_END =
        (REM == 0) ? KEEP_ALL : (KEEP_ALL >> (BYTES - REM));
    localparam logic [CNT_WIDTH-1:0]         LAST_IDX = CNT_WIDTH'(WORDS - 1);
    localparam logic [CNT_WIDTH-1:0]         IDX_ONE  = 1;
    localparam logic [QUEUE_INDEX_WIDTH-1:0] QID_ONE  = 1;
    localparam logic [STAT_WIDTH-1:0]        STAT_ONE = 1;
    localparam logic [ERR_WIDTH-1:0]         ERR_ONE  = 1;

    typedef enum logic [1:0] {S_HEAD, S_BODY, S_RESYNC} state_t;

    state_t                         state_q, state_d;
    logic [CNT_WIDTH-1:0]           idx_q, idx_d;
    logic [QUEUE_INDEX_WIDTH-1:0]   pkt_qid_q, pkt_qid_d;
    logic [15:0]                    lfsr_q;
    logic [STAT_WIDTH-1:0]          pkt_q, pkt_d, beat_q, beat_d;
    logic [ERR_WIDTH-1:0]           seq_q, seq_d, len_q, len_d, rr_q, rr_d;
    logic [QUEUE_INDEX_WIDTH-1:0]   last_q, last_d;
    logic                           base_q, base_d;
    logic                           sticky_q, sticky_d;
    logic                           pulse_q;

    logic [CNT_WIDTH-1:0]           word_cnt, exp_idx;
    logic [QUEUE_INDEX_WIDTH-1:0]   qid, cur_qid;
    logic [BYTES-1:0]               keep_exp;
    logic                           acc, seq_e, len_e, rr_e, done, err_any;
    logic                           unused_hi;

    assign word_cnt = s_axis_pkt_tdata[CNT_WIDTH-1:0];
    assign qid      = s_axis_pkt_tdata[CNT_WIDTH +: QUEUE_INDEX_WIDTH];
    assign unused_hi =
        ^s_axis_pkt_tdata[DATA_WIDTH-1:CNT_WIDTH+QUEUE_INDEX_WIDTH];

    assign s_axis_pkt_tready = ~bp_enable | (lfsr_q[7:0] >= bp_threshold);
    assign acc      = s_axis_pkt_tvalid & s_axis_pkt_tready;
    assign exp_idx  = (state_q == S_HEAD) ? '0 : idx_q;
    assign cur_qid  = (state_q == S_HEAD) ? qid : pkt_qid_q;
    assign keep_exp = s_axis_pkt_tlast ? KEEP_END : KEEP_ALL;

    function automatic logic [ERR_WIDTH-1:0] sat_inc(
        input logic [ERR_WIDTH-1:0] v
    );
        return (&v) ? v : v + ERR_ONE;
    endfunction

    // Checks are ordered so the first failing one owns the beat's error.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pkt_qid_d = pkt_qid_q;
        seq_e     = 1'b0;
        len_e     = 1'b0;
        done      = 1'b0;
        if (acc) begin
            unique case (state_q)
                S_RESYNC: begin
                    if (s_axis_pkt_tlast) state_d = S_HEAD;
                end
                default: begin
                    pkt_qid_d = cur_qid;
                    if (word_cnt != exp_idx || qid != cur_qid) begin
                        seq_e   = 1'b1;
                        state_d = s_axis_pkt_tlast ? S_HEAD : S_RESYNC;
                    end else if (s_axis_pkt_tlast && exp_idx != LAST_IDX) begin
                        len_e   = 1'b1;
                        state_d = S_HEAD;
                    end else if (!s_axis_pkt_tlast && exp_idx == LAST_IDX) begin
                        len_e   = 1'b1;
                        state_d = S_RESYNC;
                    end else if (s_axis_pkt_tkeep != keep_exp) begin
                        len_e   = 1'b1;
                        state_d = s_axis_pkt_tlast ? S_HEAD : S_RESYNC;
                    end else if (s_axis_pkt_tlast) begin
                        done    = 1'b1;
                        state_d = S_HEAD;
                    end else begin
                        idx_d   = exp_idx + IDX_ONE;
                        state_d = S_BODY;
                    end
                end
            endcase
        end
    end

    assign rr_e = done & rr_check_en & base_q &
                  (cur_qid != last_q + QID_ONE);
    assign err_any = seq_e | len_e | rr_e;

    always_comb begin
        pkt_d    = pkt_q;
        beat_d   = beat_q;
        seq_d    = seq_q;
        len_d    = len_q;
        rr_d     = rr_q;
        last_d   = last_q;
        base_d   = base_q;
        sticky_d = sticky_q;
        if (stat_clear) begin
            pkt_d    = '0;
            beat_d   = '0;
            seq_d    = '0;
            len_d    = '0;
            rr_d     = '0;
            last_d   = '0;
            base_d   = 1'b0;
            sticky_d = 1'b0;
        end else begin
            if (acc)     beat_d   = beat_q + STAT_ONE;
            if (seq_e)   seq_d    = sat_inc(seq_q);
            if (len_e)   len_d    = sat_inc(len_q);
            if (rr_e)    rr_d     = sat_inc(rr_q);
            if (err_any) sticky_d = 1'b1;
            if (done) begin
                pkt_d  = pkt_q + STAT_ONE;
                last_d = cur_qid;
                base_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_HEAD;
            idx_q     <= '0;
            pkt_qid_q <= '0;
            lfsr_q    <= LFSR_SEED;
            pkt_q     <= '0;
            beat_q    <= '0;
            seq_q     <= '0;
            len_q     <= '0;
            rr_q      <= '0;
            last_q    <= '0;
            base_q    <= 1'b0;
            sticky_q  <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pkt_qid_q <= pkt_qid_d;
            lfsr_q    <= {lfsr_q[14:0],
                          lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            pkt_q     <= pkt_d;
            beat_q    <= beat_d;
            seq_q     <= seq_d;
            len_q     <= len_d;
            rr_q      <= rr_d;
            last_q    <= last_d;
            base_q    <= base_d;
            sticky_q  <= sticky_d;
            pulse_q   <= err_any;
        end
    end

    assign pkt_count     = pkt_q;
    assign beat_count    = beat_q;
    assign err_seq_count = seq_q;
    assign err_len_count = len_q;
    assign err_rr_count  = rr_q;
    assign last_queue_id = last_q;
    assign err_sticky    = sticky_q;
    assign err_pulse     = pulse_q;

endmodule

// File: tb/tb_axis_traffic_checker.sv
// Bench for axis_traffic_checker: vector table, corner sequences and
// randomized packets against a packet-level reference model.
module tb_axis_traffic_checker;

    localparam int DW = 512;
    localparam int QW = 16;
    localparam int CW = 16;
    localparam int BY = DW / 8;

    localparam int K_OK    = 0;
    localparam int K_SEQ   = 1;
    localparam int K_EARLY = 2;
    localparam int K_LATE  = 3;
    localparam int K_KEEP  = 4;
    localparam int K_QID   = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] tdata;
    logic          tvalid, tlast, tready;
    logic [BY-1:0] tkeep;
    logic          rr_en, bp_en, stat_clear;
    logic [7:0]    bp_thr;
    logic [63:0]   pkt_count, beat_count;
    logic [31:0]   err_seq, err_len, err_rr;
    logic [QW-1:0] last_qid;
    logic          err_sticky, err_pulse;

    axis_traffic_checker #(
        .DATA_WIDTH(DW), .QUEUE_INDEX_WIDTH(QW), .CNT_WIDTH(CW),
        .PKT_LEN_BYTES(1536), .STAT_WIDTH(64), .ERR_WIDTH(32),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_pkt_tdata(tdata), .s_axis_pkt_tvalid(tvalid),
        .s_axis_pkt_tlast(tlast), .s_axis_pkt_tkeep(tkeep),
        .s_axis_pkt_tready(tready),
        .rr_check_en(rr_en), .bp_enable(bp_en), .bp_threshold(bp_thr),
        .stat_clear(stat_clear),
        .pkt_count(pkt_count), .beat_count(beat_count),
        .err_seq_count(err_seq), .err_len_count(err_len),
        .err_rr_count(err_rr), .last_queue_id(last_qid),
        .err_sticky(err_sticky), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0, cycles = 0, rdy_hi = 0, rdy_lo = 0;

    always @(negedge clk) begin
        cycles <= cycles + 1;
        if (err_pulse) pulses <= pulses + 1;
        if (tready) rdy_hi <= rdy_hi + 1;
        else rdy_lo <= rdy_lo + 1;
    end

    // Reference model: whole-packet outcomes, derived from the checking rules.
    longint m_pkt, m_beat;
    int     m_seq, m_len, m_rr, m_last, m_ev, pulse_base;
    bit     m_base, m_sticky;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        m_pkt = 0; m_beat = 0; m_seq = 0; m_len = 0; m_rr = 0;
        m_last = 0; m_base = 0; m_sticky = 0; m_ev = 0;
        pulse_base = pulses;
    endtask

    task automatic model_pkt(input int qid, input int kind, input int pos,
                             input bit rr);
        case (kind)
            K_OK: begin
                m_pkt++;
                m_beat += 24;
                if (rr && m_base && qid != ((m_last + 1) & 16'hFFFF)) begin
                    m_rr++; m_ev++; m_sticky = 1;
                end
                m_last = qid;
                m_base = 1;
            end
            K_SEQ, K_QID: begin
                m_seq++; m_beat += 24; m_ev++; m_sticky = 1;
            end
            K_EARLY: begin
                m_len++; m_beat += pos + 1; m_ev++; m_sticky = 1;
            end
            K_LATE: begin
                m_len++; m_beat += 31; m_ev++; m_sticky = 1;
            end
            default: begin
                m_len++; m_beat += 24; m_ev++; m_sticky = 1;
            end
        endcase
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pkt"}, pkt_count, 64'(m_pkt));
        chk({tag, ".beat"}, beat_count, 64'(m_beat));
        chk({tag, ".seq"}, 64'(err_seq), 64'(m_seq));
        chk({tag, ".len"}, 64'(err_len), 64'(m_len));
        chk({tag, ".rr"}, 64'(err_rr), 64'(m_rr));
        chk({tag, ".lastq"}, 64'(last_qid), 64'(m_last));
        chk({tag, ".sticky"}, 64'(err_sticky), 64'(m_sticky));
        chk({tag, ".pulses"}, 64'(pulses - pulse_base), 64'(m_ev));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [15:0] q, input logic [15:0] wc,
                              input logic last, input logic [BY-1:0] keep,
                              input logic clr);
        bit acc;
        tdata = '0;
        tdata[CW-1:0] = wc;
        tdata[CW +: QW] = q;
        tlast = last;
        tkeep = keep;
        tvalid = 1'b1;
        stat_clear = clr;
        acc = 0;
        for (int t = 0; t < 1000 && !acc; t++) begin
            @(negedge clk);
            acc = tready;
            tick();
        end
        stat_clear = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_timeout: got no tready expected accept");
        end
    endtask

    task automatic send_pkt(input int qid, input int kind, input int pos,
                            input int stop, input int clr_at, input int gap);
        int n, lastpos;
        logic [15:0] wc, q;
        logic [BY-1:0] keep;
        lastpos = (kind == K_EARLY) ? pos : (kind == K_LATE) ? 30 : 23;
        n = lastpos + 1;
        if (stop < n) n = stop;
        for (int i = 0; i < n; i++) begin
            if (gap > 0 && $urandom_range(99) < gap) begin
                tvalid = 1'b0;
                tick();
            end
            wc = 16'(i);
            q = 16'(qid);
            keep = '1;
            if (kind == K_SEQ && i == pos) wc = 16'(i + 1);
            if (kind == K_QID && i == pos) q = q ^ 16'h1;
            if (kind == K_KEEP && i == pos) keep[0] = 1'b0;
            drive_beat(q, wc, (i == lastpos), keep, (i == clr_at));
        end
        tvalid = 1'b0;
        tlast = 1'b0;
    endtask

    task automatic settle();
        tvalid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic do_clear();
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        tick();
        model_clear();
    endtask

    typedef struct {
        int qid; int kind; int pos; bit rr; bit clr;
        int pkt; int beat; int seq; int len; int rre; int lq; int pul;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int p0, lo0, c0, h0, duty, qid, kind, pos;
        bit rr;

        tbl[0]  = '{5, K_OK, 0, 1, 0, 1, 24, 0, 0, 0, 5, 0};
        tbl[1]  = '{6, K_OK, 0, 1, 0, 2, 48, 0, 0, 0, 6, 0};
        tbl[2]  = '{7, K_OK, 0, 1, 0, 3, 72, 0, 0, 0, 7, 0};
        tbl[3]  = '{'hFFFF, K_OK, 0, 1, 1, 1, 24, 0, 0, 0, 'hFFFF, 0};
        tbl[4]  = '{0, K_OK, 0, 1, 0, 2, 48, 0, 0, 0, 0, 0};
        tbl[5]  = '{2, K_OK, 0, 1, 0, 3, 72, 0, 0, 1, 2, 1};
        tbl[6]  = '{3, K_SEQ, 10, 1, 0, 3, 96, 1, 0, 1, 2, 1};
        tbl[7]  = '{3, K_OK, 0, 1, 0, 4, 120, 1, 0, 1, 3, 0};
        tbl[8]  = '{4, K_EARLY, 20, 1, 0, 4, 141, 1, 1, 1, 3, 1};
        tbl[9]  = '{4, K_LATE, 0, 1, 0, 4, 172, 1, 2, 1, 3, 1};
        tbl[10] = '{4, K_KEEP, 5, 1, 0, 4, 196, 1, 3, 1, 3, 1};
        tbl[11] = '{4, K_KEEP, 23, 1, 0, 4, 220, 1, 4, 1, 3, 1};
        tbl[12] = '{4, K_SEQ, 0, 1, 0, 4, 244, 2, 4, 1, 3, 1};
        tbl[13] = '{4, K_OK, 0, 1, 0, 5, 268, 2, 4, 1, 4, 0};
        tbl[14] = '{9, K_OK, 0, 0, 0, 6, 292, 2, 4, 1, 9, 0};
        tbl[15] = '{10, K_QID, 7, 1, 0, 6, 316, 3, 4, 1, 9, 1};
        tbl[16] = '{10, K_OK, 0, 1, 0, 7, 340, 3, 4, 1, 10, 0};

        rst_n = 1'b0;
        tdata = '0; tvalid = 0; tlast = 0; tkeep = '1;
        rr_en = 1; bp_en = 0; bp_thr = 8'd0; stat_clear = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        chk("rst.pkt", pkt_count, 64'd0);
        chk("rst.beat", beat_count, 64'd0);
        chk("rst.errs", 64'({err_seq, err_len} | 64'(err_rr)), 64'd0);
        chk("rst.lastq", 64'(last_qid), 64'd0);
        chk("rst.sticky", 64'(err_sticky), 64'd0);
        chk("rst.pulse", 64'(err_pulse), 64'd0);
        chk("rst.tready", 64'(tready), 64'd1);

        lo0 = rdy_lo;
        foreach (tbl[i]) begin
            if (tbl[i].clr) begin
                stat_clear = 1'b1;
                tick();
                stat_clear = 1'b0;
            end
            rr_en = tbl[i].rr;
            p0 = pulses;
            send_pkt(tbl[i].qid, tbl[i].kind, tbl[i].pos, 99, -1, 0);
            settle();
            chk($sformatf("v%0d.pkt", i), pkt_count, 64'(tbl[i].pkt));
            chk($sformatf("v%0d.beat", i), beat_count, 64'(tbl[i].beat));
            chk($sformatf("v%0d.seq", i), 64'(err_seq), 64'(tbl[i].seq));
            chk($sformatf("v%0d.len", i), 64'(err_len), 64'(tbl[i].len));
            chk($sformatf("v%0d.rr", i), 64'(err_rr), 64'(tbl[i].rre));
            chk($sformatf("v%0d.lastq", i), 64'(last_qid), 64'(tbl[i].lq));
            chk($sformatf("v%0d.sticky", i), 64'(err_sticky),
                64'((tbl[i].seq | tbl[i].len | tbl[i].rre) != 0));
            chk($sformatf("v%0d.pulse", i), 64'(pulses - p0),
                64'(tbl[i].pul));
        end
        chk("tbl.tready_low_cycles", 64'(rdy_lo - lo0), 64'd0);
        rr_en = 1'b1;

        // stat_clear coincides with an errored last beat
        send_pkt(30, K_KEEP, 23, 99, 23, 0);
        settle();
        chk("clr.pkt", pkt_count, 64'd0);
        chk("clr.beat", beat_count, 64'd0);
        chk("clr.len", 64'(err_len), 64'd0);
        chk("clr.errs", 64'(err_seq) | 64'(err_rr), 64'd0);
        chk("clr.lastq", 64'(last_qid), 64'd0);
        chk("clr.sticky", 64'(err_sticky), 64'd0);
        send_pkt(50, K_OK, 0, 99, -1, 0);
        settle();
        chk("clr2.pkt", pkt_count, 64'd1);
        chk("clr2.rr", 64'(err_rr), 64'd0);
        chk("clr2.lastq", 64'(last_qid), 64'd50);

        // asynchronous reset in the middle of a packet
        send_pkt(51, K_OK, 0, 10, -1, 0);
        #2;
        rst_n = 1'b0;
        #2;
        chk("arst.pkt", pkt_count, 64'd0);
        chk("arst.beat", beat_count, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send_pkt(60, K_OK, 0, 99, -1, 0);
        settle();
        chk("arst2.pkt", pkt_count, 64'd1);
        chk("arst2.beat", beat_count, 64'd24);
        chk("arst2.errs", 64'(err_seq) | 64'(err_len) | 64'(err_rr), 64'd0);
        chk("arst2.lastq", 64'(last_qid), 64'd60);

        // backpressure at threshold 128 with continuous valid
        do_clear();
        bp_en = 1'b1;
        bp_thr = 8'd128;
        c0 = cycles;
        h0 = rdy_hi;
        qid = 100;
        while (cycles - c0 < 1000) begin
            send_pkt(qid, K_OK, 0, 99, -1, 0);
            model_pkt(qid, K_OK, 0, 1);
            qid++;
        end
        duty = ((rdy_hi - h0) * 100) / (cycles - c0);
        settle();
        chk("bp.duty_in_40_60", 64'(duty >= 40 && duty <= 60), 64'd1);
        check_model("bp");
        bp_thr = 8'd0;
        lo0 = rdy_lo;
        send_pkt(qid, K_OK, 0, 99, -1, 0);
        model_pkt(qid, K_OK, 0, 1);
        settle();
        chk("bp0.tready_low_cycles", 64'(rdy_lo - lo0), 64'd0);
        check_model("bp0");

        // randomized packets with gaps and backpressure
        do_clear();
        for (int n = 0; n < 40; n++) begin
            bp_en = 1'($urandom_range(1));
            bp_thr = 8'($urandom_range(200));
            rr = 1'($urandom_range(3) != 0);
            rr_en = rr;
            qid = ($urandom_range(1) != 0) ? ((m_last + 1) & 16'hFFFF)
                                           : int'($urandom_range(16'hFFFF));
            kind = ($urandom_range(1) != 0) ? K_OK
                                            : int'($urandom_range(5));
            pos = (kind == K_KEEP) ? int'($urandom_range(23))
                                   : int'($urandom_range(22));
            send_pkt(qid, kind, pos, 99, -1, 20);
            model_pkt(qid, kind, pos, rr);
            settle();
            check_model($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
